// File: rtl/lsq_state_ctrl.sv
// State-update block for one load or store queue: circular entry array with
// head/tail pointers, multi-lane alloc, AGU writes, completion, commit and rollback.
module lsq_state_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 4,
  parameter int ID_W     = 6,
  parameter int ADDR_W   = 32,
  parameter int PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_W-1:0]           alloc_valid,
  input  logic [ALLOC_W*ID_W-1:0]      alloc_id,
  output logic                         alloc_ready,
  input  logic                         addr_wr,
  input  logic [$clog2(DEPTH)-1:0]     addr_idx,
  input  logic [ADDR_W-1:0]            addr_data,
  input  logic                         done_valid,
  input  logic [$clog2(DEPTH)-1:0]     done_idx,
  input  logic [$clog2(COMMIT_W+1)-1:0] commit_cnt,
  input  logic                         flush,
  input  logic [PTR_W-1:0]             flush_tail,
  output logic [PTR_W-1:0]             head_ptr,
  output logic [PTR_W-1:0]             tail_ptr,
  output logic [PTR_W-1:0]             count,
  output logic [PTR_W-1:0]             free_cnt,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0]             entry_addr_rdy,
  output logic [DEPTH-1:0]             entry_pending,
  output logic [DEPTH*ID_W-1:0]        entry_id,
  output logic [DEPTH*ADDR_W-1:0]      entry_addr,
  output logic                         err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  // Alloc handshake: lanes are accepted only in a cycle where alloc_ready is
  // already high; alloc_ready reflects the occupancy registered last cycle.
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]        count_q, count_d, free_q, free_d;
  logic                    full_q, full_d, empty_q, empty_d;
  logic                    ready_q, ready_d, err_q, err_d;
  logic [DEPTH-1:0]        valid_q, valid_d, rdy_q, rdy_d, pend_q, pend_d;
  logic [DEPTH*ID_W-1:0]   id_q, id_d;
  logic [DEPTH*ADDR_W-1:0] addr_q, addr_d;

  logic [31:0]       alloc_k;
  logic              run;
  logic              commit_ok, flush_ok;
  logic [PTR_W-1:0]  ft_dist, flush_len;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    valid_d = valid_q;
    rdy_d   = rdy_q;
    pend_d  = pend_q;
    id_d    = id_q;
    addr_d  = addr_q;
    idx     = '0;
    run     = 1'b1;
    alloc_k = '0;

    for (int i = 0; i < ALLOC_W; i++) begin
      if (run && alloc_valid[i]) alloc_k = alloc_k + 32'd1;
      else                       run = 1'b0;
    end

    commit_ok = 32'(commit_cnt) <= 32'(count_q);
    ft_dist   = flush_tail - head_q;
    flush_len = tail_q - flush_tail;
    // A rollback target must not fall inside the entries retiring this cycle.
    flush_ok  = flush && (32'(ft_dist) >= 32'(commit_cnt)) && (32'(ft_dist) <= 32'(count_q));

    if (!commit_ok)                                err_d = 1'b1;
    if (flush && !flush_ok)                        err_d = 1'b1;
    if (!flush && (|alloc_valid) && !ready_q)      err_d = 1'b1;

    if (addr_wr && valid_q[addr_idx]) begin
      addr_d[addr_idx*ADDR_W +: ADDR_W] = addr_data;
      rdy_d[addr_idx]  = 1'b1;
      pend_d[addr_idx] = 1'b1;
    end
    if (done_valid) pend_d[done_idx] = 1'b0;

    if (!flush && ready_q) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        if (32'(i) < alloc_k) begin
          idx = tail_q[IDX_W-1:0] + IDX_W'(i);
          valid_d[idx] = 1'b1;
          rdy_d[idx]   = 1'b0;
          pend_d[idx]  = 1'b0;
          id_d[idx*ID_W +: ID_W] = alloc_id[i*ID_W +: ID_W];
        end
      end
      tail_d = tail_q + PTR_W'(alloc_k);
    end

    // Clears run after the writes so retire/rollback win on a shared index.
    if (commit_ok) begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (32'(i) < 32'(commit_cnt)) begin
          idx = head_q[IDX_W-1:0] + IDX_W'(i);
          valid_d[idx] = 1'b0;
          rdy_d[idx]   = 1'b0;
          pend_d[idx]  = 1'b0;
        end
      end
      head_d = head_q + PTR_W'(commit_cnt);
    end

    if (flush_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (32'(i) < 32'(flush_len)) begin
          idx = flush_tail[IDX_W-1:0] + IDX_W'(i);
          valid_d[idx] = 1'b0;
          rdy_d[idx]   = 1'b0;
          pend_d[idx]  = 1'b0;
        end
      end
      tail_d = flush_tail;
    end

    count_d = tail_d - head_d;
    free_d  = DEPTH_P - count_d;
    full_d  = (count_d == DEPTH_P);
    empty_d = (count_d == '0);
    ready_d = 32'(free_d) >= 32'(ALLOC_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= DEPTH_P;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= '0;
      rdy_q   <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
    end
  end

  assign alloc_ready    = ready_q;
  assign head_ptr       = head_q;
  assign tail_ptr       = tail_q;
  assign count          = count_q;
  assign free_cnt       = free_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign entry_valid    = valid_q;
  assign entry_addr_rdy = rdy_q;
  assign entry_pending  = pend_q;
  assign entry_id       = id_q;
  assign entry_addr     = addr_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lsq_state_ctrl.sv
// Bench for lsq_state_ctrl at DEPTH=8: directed scenarios plus randomized
// traffic against an integer-pointer reference model of the queue.
module tb_lsq_state_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 4;

  logic         clk, rst;
  logic [1:0]   alloc_valid;
  logic [11:0]  alloc_id;
  logic         alloc_ready;
  logic         addr_wr;
  logic [2:0]   addr_idx;
  logic [31:0]  addr_data;
  logic         done_valid;
  logic [2:0]   done_idx;
  logic [2:0]   commit_cnt;
  logic         flush;
  logic [3:0]   flush_tail;
  logic [3:0]   head_ptr, tail_ptr, count, free_cnt;
  logic         full, empty, err;
  logic [7:0]   entry_valid, entry_addr_rdy, entry_pending;
  logic [47:0]  entry_id;
  logic [255:0] entry_addr;

  int tests_run = 0;
  int tests_failed = 0;

  lsq_state_ctrl #(.DEPTH(8), .ALLOC_W(2), .COMMIT_W(4), .ID_W(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_ready(alloc_ready),
    .addr_wr(addr_wr), .addr_idx(addr_idx), .addr_data(addr_data),
    .done_valid(done_valid), .done_idx(done_idx),
    .commit_cnt(commit_cnt), .flush(flush), .flush_tail(flush_tail),
    .head_ptr(head_ptr), .tail_ptr(tail_ptr), .count(count), .free_cnt(free_cnt),
    .full(full), .empty(empty),
    .entry_valid(entry_valid), .entry_addr_rdy(entry_addr_rdy), .entry_pending(entry_pending),
    .entry_id(entry_id), .entry_addr(entry_addr), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: unbounded-style integer pointers reduced mod 16
  int          m_head, m_tail;
  bit          m_err;
  bit          m_valid[DEPTH], m_rdy[DEPTH], m_pend[DEPTH];
  logic [5:0]  m_id[DEPTH];
  logic [31:0] m_addr[DEPTH];

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_err = 0;
    for (int s = 0; s < DEPTH; s++) begin
      m_valid[s] = 0; m_rdy[s] = 0; m_pend[s] = 0; m_id[s] = '0; m_addr[s] = '0;
    end
  endtask

  task automatic model_step();
    int occ, k, cc, ft, fd, flen, s;
    bit ready, cok, fok;
    occ   = (m_tail - m_head) & 15;
    ready = (DEPTH - occ) >= 2;
    cc    = int'(commit_cnt);
    ft    = int'(flush_tail);
    k     = alloc_valid[0] ? (alloc_valid[1] ? 2 : 1) : 0;
    cok   = cc <= occ;
    fd    = (ft - m_head) & 15;
    fok   = flush && fd >= cc && fd <= occ;
    if (!cok) m_err = 1;
    if (flush && !fok) m_err = 1;
    if (!flush && alloc_valid != 2'b00 && !ready) m_err = 1;
    if (addr_wr && m_valid[addr_idx]) begin
      m_addr[addr_idx] = addr_data; m_rdy[addr_idx] = 1; m_pend[addr_idx] = 1;
    end
    if (done_valid) m_pend[done_idx] = 0;
    if (!flush && ready) begin
      for (int i = 0; i < k; i++) begin
        s = (m_tail + i) & 7;
        m_valid[s] = 1; m_rdy[s] = 0; m_pend[s] = 0;
        m_id[s] = alloc_id[i*6 +: 6];
      end
      m_tail = (m_tail + k) & 15;
    end
    if (cok) begin
      for (int i = 0; i < cc; i++) begin
        s = (m_head + i) & 7;
        m_valid[s] = 0; m_rdy[s] = 0; m_pend[s] = 0;
      end
      m_head = (m_head + cc) & 15;
    end
    if (fok) begin
      flen = (m_tail - ft) & 15;
      for (int i = 0; i < flen; i++) begin
        s = (ft + i) & 7;
        m_valid[s] = 0; m_rdy[s] = 0; m_pend[s] = 0;
      end
      m_tail = ft;
    end
  endtask

  // driver tasks
  task automatic idle();
    alloc_valid = '0; alloc_id = '0; addr_wr = 0; addr_idx = '0; addr_data = '0;
    done_valid = 0; done_idx = '0; commit_cnt = '0; flush = 0; flush_tail = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic alloc_pair(input logic [5:0] id0, input logic [5:0] id1);
    alloc_valid = 2'b11;
    alloc_id = {id1, id0};
    tick();
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({head_ptr, tail_ptr, count, free_cnt} !== {4'd0, 4'd0, 4'd0, 4'd8}) begin
      tests_failed++;
      $display("FAIL reset_ptrs: got h=%0d t=%0d c=%0d f=%0d expected 0 0 0 8", head_ptr, tail_ptr, count, free_cnt);
    end
    tests_run++;
    if ({empty, full, err, alloc_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL reset_flags: got e/f/err/rdy=%b expected 1001", {empty, full, err, alloc_ready});
    end
    tests_run++;
    if ({entry_valid, entry_addr_rdy, entry_pending} !== 24'h0 || entry_id !== '0 || entry_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset_entries: got v=%h r=%h p=%h expected all zero", entry_valid, entry_addr_rdy, entry_pending);
    end
  endtask

  task automatic test_fill_and_commit();
    do_reset();
    for (int c = 0; c < 4; c++) alloc_pair(6'd5, 6'd6);
    tests_run++;
    if (tail_ptr !== 4'b1000 || count !== 4'd8 || full !== 1'b1 || alloc_ready !== 1'b0 || entry_valid !== 8'hFF) begin
      tests_failed++;
      $display("FAIL fill: got t=%b c=%0d full=%b rdy=%b v=%h expected 1000 8 1 0 ff", tail_ptr, count, full, alloc_ready, entry_valid);
    end
    tests_run++;
    if (entry_id[0 +: 6] !== 6'd5 || entry_id[6 +: 6] !== 6'd6 || entry_id[42 +: 6] !== 6'd6) begin
      tests_failed++;
      $display("FAIL fill_ids: got %0d %0d %0d expected 5 6 6", entry_id[0 +: 6], entry_id[6 +: 6], entry_id[42 +: 6]);
    end
    commit_cnt = 3'd3;
    tick();
    alloc_pair(6'd9, 6'd10);
    tests_run++;
    if (head_ptr !== 4'd3 || tail_ptr !== 4'd10 || count !== 4'd7 || entry_valid !== 8'hFB) begin
      tests_failed++;
      $display("FAIL commit_alloc: got h=%0d t=%0d c=%0d v=%h expected 3 10 7 fb", head_ptr, tail_ptr, count, entry_valid);
    end
    tests_run++;
    if (entry_id[0 +: 6] !== 6'd9 || entry_id[6 +: 6] !== 6'd10 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_ids: got %0d %0d err=%b expected 9 10 0", entry_id[0 +: 6], entry_id[6 +: 6], err);
    end
  endtask

  task automatic test_full_alloc_commit();
    do_reset();
    for (int c = 0; c < 4; c++) alloc_pair(6'd1, 6'd2);
    commit_cnt = 3'd1;
    alloc_valid = 2'b11;
    alloc_id = {6'd33, 6'd44};
    tick();
    tests_run++;
    if (head_ptr !== 4'd1 || tail_ptr !== 4'd8 || count !== 4'd7 || entry_valid !== 8'hFE || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_alloc_commit: got h=%0d t=%0d c=%0d v=%h err=%b expected 1 8 7 fe 1",
               head_ptr, tail_ptr, count, entry_valid, err);
    end
  endtask

  task automatic test_addr_done();
    do_reset();
    alloc_pair(6'd1, 6'd2);
    alloc_pair(6'd3, 6'd4);
    addr_wr = 1; addr_idx = 3'd2; addr_data = 32'h100;
    tick();
    tests_run++;
    if (entry_addr_rdy[2] !== 1'b1 || entry_pending[2] !== 1'b1 || entry_addr[64 +: 32] !== 32'h100) begin
      tests_failed++;
      $display("FAIL addr_write: got rdy=%b pend=%b addr=%h expected 1 1 100", entry_addr_rdy[2], entry_pending[2], entry_addr[64 +: 32]);
    end
    done_valid = 1; done_idx = 3'd2;
    tick();
    tests_run++;
    if (entry_addr_rdy[2] !== 1'b1 || entry_pending[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL done: got rdy=%b pend=%b expected 1 0", entry_addr_rdy[2], entry_pending[2]);
    end
    addr_wr = 1; addr_idx = 3'd3; addr_data = 32'hABC; done_valid = 1; done_idx = 3'd3;
    tick();
    tests_run++;
    if (entry_addr_rdy[3] !== 1'b1 || entry_pending[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_done_same: got rdy=%b pend=%b expected 1 0", entry_addr_rdy[3], entry_pending[3]);
    end
    addr_wr = 1; addr_idx = 3'd5; addr_data = 32'hDEAD;
    tick();
    tests_run++;
    if (entry_addr_rdy[5] !== 1'b0 || entry_pending[5] !== 1'b0 || entry_addr[160 +: 32] !== 32'h0) begin
      tests_failed++;
      $display("FAIL addr_invalid: got rdy=%b pend=%b addr=%h expected 0 0 0", entry_addr_rdy[5], entry_pending[5], entry_addr[160 +: 32]);
    end
  endtask

  task automatic test_flush_beats_alloc();
    do_reset();
    for (int c = 0; c < 3; c++) alloc_pair(6'd7, 6'd8);
    flush = 1; flush_tail = 4'd3; alloc_valid = 2'b01; alloc_id = 12'd20;
    tick();
    tests_run++;
    if (tail_ptr !== 4'd3 || count !== 4'd3 || entry_valid !== 8'h07 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush: got t=%0d c=%0d v=%h err=%b expected 3 3 07 0", tail_ptr, count, entry_valid, err);
    end
  endtask

  task automatic test_commit_overrun();
    do_reset();
    alloc_pair(6'd1, 6'd2);
    commit_cnt = 3'd3;
    tick();
    tests_run++;
    if (head_ptr !== 4'd0 || count !== 4'd2 || entry_valid !== 8'h03 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL commit_overrun: got h=%0d c=%0d v=%h err=%b expected 0 2 03 1", head_ptr, count, entry_valid, err);
    end
    commit_cnt = 3'd2;
    tick();
    tick();
    tests_run++;
    if (err !== 1'b1 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b empty=%b expected 1 1", err, empty);
    end
    do_reset();
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cleared: got %b expected 0", err);
    end
  endtask

  task automatic test_clear_beats_addr();
    do_reset();
    alloc_pair(6'd1, 6'd2);
    commit_cnt = 3'd1; addr_wr = 1; addr_idx = 3'd0; addr_data = 32'h55;
    tick();
    tests_run++;
    if (entry_valid !== 8'h02 || entry_addr_rdy[0] !== 1'b0 || head_ptr !== 4'd1) begin
      tests_failed++;
      $display("FAIL clear_beats_addr: got v=%h rdy0=%b h=%0d expected 02 0 1", entry_valid, entry_addr_rdy[0], head_ptr);
    end
  endtask

  task automatic test_bad_flush();
    do_reset();
    alloc_pair(6'd1, 6'd2);
    alloc_pair(6'd3, 6'd4);
    commit_cnt = 3'd2; flush = 1; flush_tail = 4'd1;
    tick();
    tests_run++;
    if (tail_ptr !== 4'd4 || head_ptr !== 4'd2 || entry_valid !== 8'h0C || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_flush: got t=%0d h=%0d v=%h err=%b expected 4 2 0c 1", tail_ptr, head_ptr, entry_valid, err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_pair(6'd1, 6'd2);
    alloc_valid = 2'b11; alloc_id = {6'd3, 6'd4};
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (head_ptr !== 4'd0 || tail_ptr !== 4'd0 || entry_valid !== 8'h00 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: got h=%0d t=%0d v=%h empty=%b expected 0 0 00 1", head_ptr, tail_ptr, entry_valid, empty);
    end
    @(posedge clk);
    #1;
    idle();
    model_reset();
    rst = 1'b0;
    tick();
    tests_run++;
    if (tail_ptr !== 4'd0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_discard: got t=%0d c=%0d expected 0 0", tail_ptr, count);
    end
  endtask

  task automatic test_random();
    int occ, cc, mx;
    logic [7:0] ev, er, ep;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      occ = (m_tail - m_head) & 15;
      case ($urandom_range(0, 3))
        0:       alloc_valid = 2'b00;
        1:       alloc_valid = 2'b01;
        default: alloc_valid = 2'b11;
      endcase
      alloc_id   = 12'($urandom);
      addr_wr    = 1'($urandom_range(0, 1));
      addr_idx   = 3'($urandom_range(0, 7));
      addr_data  = $urandom;
      done_valid = ($urandom_range(0, 2) == 0);
      done_idx   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) cc = $urandom_range(0, 4);
      else begin
        mx = (occ < 4) ? occ : 4;
        cc = $urandom_range(0, mx);
      end
      commit_cnt = 3'(cc);
      flush = ($urandom_range(0, 11) == 0);
      if (cc <= occ && $urandom_range(0, 4) != 0)
        flush_tail = 4'((m_head + cc + $urandom_range(0, occ - cc)) & 15);
      else
        flush_tail = 4'($urandom_range(0, 15));
      tick();

      for (int s = 0; s < DEPTH; s++) begin
        ev[s] = m_valid[s]; er[s] = m_rdy[s]; ep[s] = m_pend[s];
      end
      tests_run++;
      if (head_ptr !== 4'(m_head) || tail_ptr !== 4'(m_tail) || count !== 4'((m_tail - m_head) & 15) ||
          free_cnt !== 4'(DEPTH - ((m_tail - m_head) & 15))) begin
        tests_failed++;
        $display("FAIL rand_ptrs cyc %0d: got h=%0d t=%0d c=%0d f=%0d expected h=%0d t=%0d", c,
                 head_ptr, tail_ptr, count, free_cnt, m_head, m_tail);
      end
      tests_run++;
      if (full !== (((m_tail - m_head) & 15) == DEPTH) || empty !== (m_tail == m_head) ||
          alloc_ready !== ((DEPTH - ((m_tail - m_head) & 15)) >= 2) || err !== m_err) begin
        tests_failed++;
        $display("FAIL rand_flags cyc %0d: got full=%b empty=%b rdy=%b err=%b expected err=%b", c,
                 full, empty, alloc_ready, err, m_err);
      end
      tests_run++;
      if (entry_valid !== ev || entry_addr_rdy !== er || entry_pending !== ep) begin
        tests_failed++;
        $display("FAIL rand_bits cyc %0d: got v=%h r=%h p=%h expected v=%h r=%h p=%h", c,
                 entry_valid, entry_addr_rdy, entry_pending, ev, er, ep);
      end
      for (int s = 0; s < DEPTH; s++) begin
        if (m_valid[s]) begin
          tests_run++;
          if (entry_id[s*6 +: 6] !== m_id[s]) begin
            tests_failed++;
            $display("FAIL rand_id cyc %0d slot %0d: got %0d expected %0d", c, s, entry_id[s*6 +: 6], m_id[s]);
          end
        end
        if (m_rdy[s]) begin
          tests_run++;
          if (entry_addr[s*32 +: 32] !== m_addr[s]) begin
            tests_failed++;
            $display("FAIL rand_addr cyc %0d slot %0d: got %h expected %h", c, s, entry_addr[s*32 +: 32], m_addr[s]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_fill_and_commit();
    test_full_alloc_commit();
    test_addr_done();
    test_flush_beats_alloc();
    test_commit_overrun();
    test_clear_beats_addr();
    test_bad_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsq_state_ctrl.md
Name: lsq_state_ctrl

Overview:
- Parametrised state-update block for one load or store queue in the out-of-order memory path. Instantiated twice: once for loads, once for stores.
- Owns the queue's circular entry array and head/tail pointers. Applies, in one clocked step, multi-lane allocation, AGU address writes, cache-completion clears, multi-entry in-order commit, and branch-misprediction rollback of the tail.
- Adds occupancy tracking, full/empty flags, a free-slot count, a rollback path and a sticky protocol-error flag. The earlier fixed-size update logic has none of these.

Parameters:
DEPTH, 16, queue entries; power of two, minimum 4
ALLOC_W, 2, allocation lanes per cycle
COMMIT_W, 4, maximum entries retired per cycle
ID_W, 6, active-list id width
ADDR_W, 32, memory address width
PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
alloc_valid  in  ALLOC_W  per-lane allocate request; must be contiguous from lane 0
alloc_id  in  ALLOC_W*ID_W  active-list id per lane
alloc_ready  out  1  high when free_cnt >= ALLOC_W
addr_wr  in  1  AGU address write
addr_idx  in  $clog2(DEPTH)  entry written
addr_data  in  ADDR_W  computed address
done_valid  in  1  cache hit completed for entry done_idx
done_idx  in  $clog2(DEPTH)  completed entry
commit_cnt  in  $clog2(COMMIT_W+1)  entries retiring from head this cycle
flush  in  1  misprediction rollback
flush_tail  in  PTR_W  checkpointed tail pointer to restore
head_ptr  out  PTR_W  oldest entry
tail_ptr  out  PTR_W  next allocation slot
count  out  PTR_W  occupied entries
free_cnt  out  PTR_W  DEPTH - count
full  out  1  count == DEPTH
empty  out  1  count == 0
entry_valid  out  DEPTH  entry allocated
entry_addr_rdy  out  DEPTH  address written
entry_pending  out  DEPTH  address written, access not yet completed
entry_id  out  DEPTH*ID_W  id per entry
entry_addr  out  DEPTH*ADDR_W  address per entry
err  out  1  sticky protocol error

Behaviour:
- Reset state (asynchronous on rst): head_ptr=0, tail_ptr=0, count=0, empty=1, full=0, free_cnt=DEPTH, err=0. All entry bit vectors are 0. entry_id and entry_addr are 0.
- All outputs are registered. Every update is visible the cycle after its inputs are sampled.
- Index of a pointer is ptr[PTR_W-2:0]. count = tail - head, modulo 2^PTR_W.
- Alloc: for k contiguous valid lanes with alloc_ready=1:
  - entry tail+i gets valid=1, addr_rdy=0, pending=0, id=alloc_id[i].
  - tail advances by k.
  - Alloc while alloc_ready=0 is dropped and sets err.
- Addr write: sets addr_data, addr_rdy=1 and pending=1 on addr_idx. A write to an invalid entry is ignored.
- Done: clears pending on done_idx. It is ignored when the entry is not pending.
- Commit: clears valid/addr_rdy/pending on entries head..head+commit_cnt-1, with wrap. Head advances by commit_cnt. If commit_cnt > count, nothing is committed and err is set.
- Flush:
  - tail becomes flush_tail.
  - Entries from flush_tail up to the old tail-1 get all bits cleared.
  - Legal only if flush_tail lies in [head+commit_cnt, old tail]. Otherwise err is set and the flush is ignored.
- Same-cycle priority:
  - flush beats alloc: alloc is dropped with no err.
  - commit and flush both apply.
  - commit/flush clear beats addr write or done on the same index.
  - addr write and done on the same index: pending ends 0, addr_rdy ends 1.
- Wrap: pointers roll over modulo 2^PTR_W. full and empty are distinguished by the wrap bit.
- Simultaneous alloc and commit while full: commit frees slots only next cycle, so alloc_ready stays 0 that cycle.
- err is cleared only by rst.
- rst asserted mid-operation discards all in-flight updates immediately.

Test Plan (DEPTH=8, ALLOC_W=2, COMMIT_W=4):
- Reset, then alloc 2 lanes (ids 5,6) for 4 cycles -> tail=8 (binary 1000), count=8, full=1, alloc_ready=0, entry_valid=0xFF.
- From full: commit_cnt=3, then alloc 2 (ids 9,10) -> head=3, tail=10, count=7, entries 0,1 valid with ids 9,10.
- Addr write idx 2 addr 0x100, next cycle done idx 2 -> entry_addr_rdy[2]=1 and entry_pending[2]=1, then entry_pending[2]=0.
- head=0, tail=6, flush_tail=3 with alloc lane 0 asserted -> tail=3, count=3, entry_valid=0x07, alloc dropped, err=0.
- count=2, commit_cnt=3 -> head unchanged, err=1 held until rst.
- Same cycle: commit_cnt=1 on head index 0 and addr write idx 0 -> entry 0 invalid, addr_rdy[0]=0, head=1.
